imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl_pkg.sv | 19 +
 rtl/imem_fetch_ctrl_fetch_queue.sv | 52 +++++
 rtl/imem_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int ENTRY_N    = 32;
    localparam int ENTRY_PC_W = 64;
    localparam int PC_STEP    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [ENTRY_N-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Small power-of-two FIFO holding prefetched {pc, instr} words.
// Flush has priority over push/pop; the caller never pushes into a full
// queue unless it also pops in the same cycle.
module fetch_queue #(
    parameter  int W  = 96,
    parameter  int QD = 2,
    localparam int PW = $clog2(QD),
    localparam int CW = $clog2(QD) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [QD];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: the head is masked by the top while empty
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for the 128-word LEGv8 instruction ROM.
// Owns the fetch PC, prefetches into a small queue and hands {pc, instr}
// to decode over valid/ready. Optional perf counters: FETCH_PERF_EN.
//
// state | meaning
// IDLE  | fetch disabled, queue contents retained
// FETCH | reading one ROM word per cycle while the queue has room
// HALT  | PC left the ROM range; queue drains, leave only via redirect
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int N    = 32,
    parameter int AW   = 7,
    parameter int PC_W = 64,
    parameter int QD   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_en,
    output logic [AW-1:0]   imem_addr,
    input  logic [N-1:0]    imem_q,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_redirects
`endif
);

    localparam int CW = $clog2(QD) + 1;
    localparam int W  = PC_W + N;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [CW-1:0]   q_count;
    logic [W-1:0]    q_dout;
    logic            has_data, pc_oor, redirect_oor;
    logic            push, pop;

    // anything above byte address 0x1FF lies outside the ROM
    assign pc_oor       = (pc_q >> (AW + 2)) != '0;
    assign redirect_oor = (redirect_pc >> (AW + 2)) != '0;

    assign has_data  = q_count != '0;
    assign out_valid = has_data && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = (state_q == FETCH) && !redirect_valid && !pc_oor &&
                       ((q_count < CW'(QD)) || pop);

    assign imem_addr = pc_q[AW+1:2];
    assign out_pc    = has_data ? q_dout[N +: PC_W] : '0;
    assign out_instr = has_data ? q_dout[N-1:0]     : '0;
    assign halted    = (state_q == HALT);

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next state: a redirect overrides everything, out-of-range beats fetch_en
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            if (redirect_oor)  state_d = HALT;
            else if (fetch_en) state_d = FETCH;
            else               state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (fetch_en) state_d = FETCH;
                FETCH: begin
                    if (pc_oor)         state_d = HALT;
                    else if (!fetch_en) state_d = IDLE;
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // fetch PC: redirect target stored verbatim, else advance per pushed word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            pc_q <= '0;
        else if (redirect_valid) pc_q <= redirect_pc;
        else if (push)           pc_q <= pc_q + PC_W'(PC_STEP);
    end

    fetch_queue #(
        .W  (W),
        .QD (QD)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .din     ({pc_q, imem_q}),
        .dout    (q_dout),
        .count   (q_count)
    );

`ifdef FETCH_PERF_EN
    // saturating event counters for pushes and accepted redirects
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (push && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: the driver predicts every fetched
// word from a behavioural model and queues it; a monitor compares whatever
// decode accepts against the front of that queue.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [6:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    logic [31:0] rom [128];
    assign imem_q = rom[imem_addr];

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          done = 0;

    // reference model: fetching / halted flags, PC and event counts
    bit          m_running = 0;
    bit          m_halted  = 0;
    logic [63:0] m_pc      = '0;
    int          m_fetched = 0;
    int          m_redirs  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rom(input logic [63:0] p);
        return (p >> 9) == 64'd0;
    endfunction

    // one clock of stimulus; model step happens just before the rising edge
    task automatic cycle(input bit fen, input bit rv, input logic [63:0] rpc,
                         input bit ordy, input bit rst = 1'b0);
        int   cnt0;
        bit   pop;
        exp_t e;
        @(negedge clk);
        reset_n        = 1'b1;
        fetch_en       = fen;
        redirect_valid = rst ? 1'b0 : rv;
        redirect_pc    = rpc;
        out_ready      = ordy;
        if (rst) begin
            reset_n = 1'b0;
            sb.delete();
            m_running = 0;
            m_halted  = 0;
            m_pc      = '0;
            m_fetched = 0;
            m_redirs  = 0;
            #1;
            chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
            chk("async_rst_addr", {57'd0, imem_addr}, 64'd0);
            chk("async_rst_halted", {63'd0, halted}, 64'd0);
            #2;
        end else begin
            #1;
            cnt0 = sb.size();
            #2;
            if (rv) begin
                sb.delete();
                m_pc      = rpc;
                m_halted  = !in_rom(rpc);
                m_running = !m_halted && fen;
                m_redirs++;
            end else begin
                pop = (cnt0 != 0) && ordy;
                if (m_running) begin
                    if (!in_rom(m_pc)) begin
                        m_running = 0;
                        m_halted  = 1;
                    end else begin
                        if (cnt0 < 2 || pop) begin
                            e.pc    = m_pc;
                            e.instr = rom[m_pc[8:2]];
                            sb.push_back(e);
                            m_pc = m_pc + 64'd4;
                            m_fetched++;
                        end
                        if (!fen) m_running = 0;
                    end
                end else if (!m_halted && fen) begin
                    m_running = 1;
                end
            end
        end
    endtask

    // monitor: checks handshake/status every cycle, pops on each acceptance
    initial begin
        exp_t e;
        bit   exp_v;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            exp_v = (sb.size() != 0) && !redirect_valid;
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
            chk("halted", {63'd0, halted}, {63'd0, m_halted});
            if (sb.size() == 0) begin
                chk("empty_pc", out_pc, 64'd0);
                chk("empty_instr", {32'd0, out_instr}, 64'd0);
            end else if (exp_v && out_valid && out_ready) begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
            end
        end
    end

    initial begin
        logic [63:0] rpc;
        int          r;
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        rom[0] = 32'hf800_0001;

        // held in reset: reset values
        @(negedge clk);
        #1;
        chk("rst_addr", {57'd0, imem_addr}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        @(negedge clk);

        // first words, back-to-back consumption
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
        // decode stalls: queue fills, head holds
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
        // redirect to 0x74 while full, with out_ready high
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 64'h74, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
        // end of ROM: words 126, 127 then halt and drain
        cycle(1, 1, 64'h1F8, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
        // redirect back to 0 leaves HALT
        cycle(1, 1, 64'h0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
        // out-of-range target: immediate halt
        cycle(1, 1, 64'h400, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
        // redirect into IDLE, then enable, then reset mid-fetch
        cycle(0, 1, 64'h10, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       rpc = {55'd0, 7'($urandom_range(0, 127)), 2'b00};
                1:       rpc = 64'h1E0 + 64'($urandom_range(0, 31));
                2:       rpc = {$urandom, $urandom};
                default: rpc = {55'd0, $urandom_range(0, 511)};
            endcase
            cycle($urandom_range(0, 99) < 85, r < 7, rpc,
                  $urandom_range(0, 99) < 65, r == 99);
        end

`ifdef FETCH_PERF_EN
        #1;
        chk("perf_fetched", {32'd0, perf_fetched}, 64'(m_fetched));
        chk("perf_redirects", {32'd0, perf_redirects}, 64'(m_redirs));
`endif

        @(negedge clk);
        done = 1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
